// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-port word memory with combinational read.
// One request in flight at a time; strobes and response are all registered.
module mem_access_unit #(
  parameter int n           = 64,
  parameter int LogSize     = 10,
  parameter int ReadLatency = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [n-1:0] resp_rdata,
  output logic         resp_err,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [n-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

  localparam logic [3:0] CntInit = 4'(ReadLatency - 1);

  state_t       state_q, state_d;
  logic         req_ready_q, req_ready_d;
  logic         resp_valid_q, resp_valid_d;
  logic [n-1:0] resp_rdata_q, resp_rdata_d;
  logic         resp_err_q, resp_err_d;
  logic [n-1:0] mem_addr_q, mem_addr_d;
  logic [n-1:0] mem_wdata_q, mem_wdata_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         out_of_range;

  assign out_of_range = |req_addr[n-1:LogSize];

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          // Out-of-range requests never touch the memory.
          if (out_of_range) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_write) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = READ_WAIT;
            mem_read_d = 1'b1;
            mem_addr_d = req_addr;
            cnt_d      = CntInit;
          end
        end
      end
      WRITE: begin
        mem_write_d  = 1'b0;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          mem_read_d   = 1'b0;
          resp_rdata_d = mem_rdata;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three units (ReadLatency 1, 3, 4), each with its
// own word memory, checked every cycle against a transaction-timing model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_ready;

  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];
  logic [63:0] mem_addr   [3];
  logic [63:0] mem_wdata  [3];
  logic        mem_read   [3];
  logic        mem_write  [3];
  logic [63:0] mem_rdata  [3];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model of each unit: the current transaction and when its phases occur.
  bit          m_busy [3];
  bit          m_wr   [3];
  bit          m_oor  [3];
  int          m_acc  [3];
  int          m_rs   [3];
  logic [63:0] m_addr [3];
  logic [63:0] m_wdata[3];
  logic [63:0] m_data [3];
  logic [63:0] m_mem  [3][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int Rl = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [63:0] mem [1024];

    mem_access_unit #(.n(64), .LogSize(10), .ReadLatency(Rl)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .mem_rdata (mem_rdata[g])
    );

    // Word memory: write on the clock edge, combinational gated read.
    always @(posedge clk) begin
      if (mem_write[g]) mem[mem_addr[g][9:0]] <= mem_wdata[g];
    end
    assign mem_rdata[g] = mem_read[g] ? mem[mem_addr[g][9:0]] : 64'd0;
  end

  function automatic int rlOf(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model over the edge that just ended cycle edge_n.
  task automatic modelEdge(int i);
    if (!rst_n) begin
      m_busy[i] = 1'b0;
    end else if (m_busy[i]) begin
      if (edge_n >= m_rs[i] && resp_ready) m_busy[i] = 1'b0;
    end else if (req_valid[i]) begin
      m_busy[i]  = 1'b1;
      m_acc[i]   = edge_n;
      m_wr[i]    = req_write;
      m_addr[i]  = req_addr;
      m_wdata[i] = req_wdata;
      m_oor[i]   = (req_addr >> 10) != 64'd0;
      if (m_oor[i])      m_rs[i] = edge_n + 1;
      else if (req_write) m_rs[i] = edge_n + 2;
      else               m_rs[i] = edge_n + rlOf(i) + 1;
      if (!m_oor[i] && req_write) m_mem[i][req_addr[9:0]] = req_wdata;
      m_data[i] = (m_oor[i] || req_write) ? 64'd0 : m_mem[i][req_addr[9:0]];
    end
  endtask

  task automatic compareModel(int i);
    int   cur;
    logic ev, er, ew;
    cur = edge_n + 1;
    ev = m_busy[i] && (cur >= m_rs[i]);
    er = m_busy[i] && !m_wr[i] && !m_oor[i] && (cur >= m_acc[i] + 1) && (cur <= m_acc[i] + rlOf(i));
    ew = m_busy[i] && m_wr[i] && !m_oor[i] && (cur == m_acc[i] + 1);
    checkOutput($sformatf("u%0d.req_ready@%0d", i, cur), 64'(req_ready[i]), 64'(!m_busy[i]));
    checkOutput($sformatf("u%0d.resp_valid@%0d", i, cur), 64'(resp_valid[i]), 64'(ev));
    checkOutput($sformatf("u%0d.resp_err@%0d", i, cur), 64'(resp_err[i]), 64'(ev && m_oor[i]));
    checkOutput($sformatf("u%0d.mem_read@%0d", i, cur), 64'(mem_read[i]), 64'(er));
    checkOutput($sformatf("u%0d.mem_write@%0d", i, cur), 64'(mem_write[i]), 64'(ew));
    if (ev) checkOutput($sformatf("u%0d.resp_rdata@%0d", i, cur), resp_rdata[i], m_data[i]);
    if (er || ew) checkOutput($sformatf("u%0d.mem_addr@%0d", i, cur), mem_addr[i], m_addr[i]);
    if (ew) checkOutput($sformatf("u%0d.mem_wdata@%0d", i, cur), mem_wdata[i], m_wdata[i]);
  endtask

  // Every cycle: step the model over the edge, then compare 1 time unit later.
  initial begin
    for (int i = 0; i < 3; i++) m_busy[i] = 1'b0;
    forever begin
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 3; i++) modelEdge(i);
      #1;
      for (int i = 0; i < 3; i++) compareModel(i);
    end
  end

  // Present one request to unit i; returns at the negedge of the cycle after acceptance.
  task automatic applyStimulus(int i, logic wr, logic [63:0] addr, logic [63:0] wd);
    int waited = 0;
    @(negedge clk);
    req_write    = wr;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid[i] = 1'b1;
    while (!req_ready[i] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput($sformatf("u%0d.accept_within_budget", i), 64'(req_ready[i]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_write  = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    for (int i = 0; i < 3; i++) req_valid[i] = 1'b0;

    // Reset held for three cycles, then idle.
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst.req_ready", 64'(req_ready[0]), 64'd1);
      checkOutput("rst.resp_valid", 64'(resp_valid[0]), 64'd0);
      checkOutput("rst.mem_strobes", {62'd0, mem_read[0], mem_write[0]}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("idle.req_ready", 64'(req_ready[0]), 64'd1);
      checkOutput("idle.mem_strobes", {62'd0, mem_read[0], mem_write[0]}, 64'd0);
    end

    // Store then load on the ReadLatency=1 unit.
    applyStimulus(0, 1'b1, 64'h10, 64'hDEADBEEF_01234567);
    checkOutput("st.T1.mem_write", 64'(mem_write[0]), 64'd1);
    checkOutput("st.T1.mem_addr", mem_addr[0], 64'h10);
    checkOutput("st.T1.resp_valid", 64'(resp_valid[0]), 64'd0);
    @(negedge clk);
    checkOutput("st.T2.mem_write", 64'(mem_write[0]), 64'd0);
    checkOutput("st.T2.resp_valid", 64'(resp_valid[0]), 64'd1);
    checkOutput("st.T2.resp_rdata", resp_rdata[0], 64'd0);
    applyStimulus(0, 1'b0, 64'h10, 64'd0);
    checkOutput("ld.T1.mem_read", 64'(mem_read[0]), 64'd1);
    @(negedge clk);
    checkOutput("ld.T2.mem_read", 64'(mem_read[0]), 64'd0);
    checkOutput("ld.T2.resp_valid", 64'(resp_valid[0]), 64'd1);
    checkOutput("ld.T2.resp_rdata", resp_rdata[0], 64'hDEADBEEF_01234567);

    // ReadLatency=3 unit: last word stored at the top address is read back.
    applyStimulus(1, 1'b1, 64'h3FF, 64'h01234567_89ABCDEF);
    applyStimulus(1, 1'b1, 64'h3FF, 64'hCAFEF00D_5555AAAA);
    applyStimulus(1, 1'b0, 64'h3FF, 64'd0);
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("lat3.T%0d.mem_read", k), 64'(mem_read[1]), 64'd1);
      checkOutput($sformatf("lat3.T%0d.resp_valid", k), 64'(resp_valid[1]), 64'd0);
      @(negedge clk);
    end
    checkOutput("lat3.T4.mem_read", 64'(mem_read[1]), 64'd0);
    checkOutput("lat3.T4.resp_valid", 64'(resp_valid[1]), 64'd1);
    checkOutput("lat3.T4.resp_rdata", resp_rdata[1], 64'hCAFEF00D_5555AAAA);

    // Out-of-range load and store; address 0 must keep its word.
    applyStimulus(0, 1'b1, 64'h0, 64'h00000000_00001111);
    applyStimulus(0, 1'b0, 64'h400, 64'd0);
    checkOutput("oor_ld.resp_err", 64'(resp_err[0]), 64'd1);
    checkOutput("oor_ld.resp_rdata", resp_rdata[0], 64'd0);
    checkOutput("oor_ld.mem_read", 64'(mem_read[0]), 64'd0);
    applyStimulus(0, 1'b1, 64'hFFFF0000_00000000, 64'h99999999_99999999);
    checkOutput("oor_st.resp_err", 64'(resp_err[0]), 64'd1);
    checkOutput("oor_st.mem_write", 64'(mem_write[0]), 64'd0);
    applyStimulus(0, 1'b0, 64'h0, 64'd0);
    @(negedge clk);
    checkOutput("oor.addr0_unchanged", resp_rdata[0], 64'h00000000_00001111);
    @(negedge clk);

    // Response backpressure with a pending store held on req_valid.
    resp_ready = 1'b0;
    applyStimulus(0, 1'b0, 64'h10, 64'd0);
    req_write    = 1'b1;
    req_addr     = 64'h20;
    req_wdata    = 64'h0000ABCD_0000ABCD;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp.resp_valid", 64'(resp_valid[0]), 64'd1);
      checkOutput("bp.resp_rdata", resp_rdata[0], 64'hDEADBEEF_01234567);
      checkOutput("bp.req_ready", 64'(req_ready[0]), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.release.req_ready", 64'(req_ready[0]), 64'd1);
    checkOutput("bp.release.mem_write", 64'(mem_write[0]), 64'd0);
    @(negedge clk);
    checkOutput("bp.accept.mem_write", 64'(mem_write[0]), 64'd1);
    checkOutput("bp.accept.mem_addr", mem_addr[0], 64'h20);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the second read cycle of the ReadLatency=4 unit.
    applyStimulus(2, 1'b0, 64'h5, 64'd0);
    checkOutput("rstmid.T1.mem_read", 64'(mem_read[2]), 64'd1);
    @(negedge clk);
    checkOutput("rstmid.T2.mem_read", 64'(mem_read[2]), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.async.mem_read", 64'(mem_read[2]), 64'd0);
    checkOutput("rstmid.async.req_ready", 64'(req_ready[2]), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("rstmid.after.resp_valid", 64'(resp_valid[2]), 64'd0);
      checkOutput("rstmid.after.req_ready", 64'(req_ready[2]), 64'd1);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller for the single-port word memory, which has combinational read (memRead-gated DataOut) and a write on the clock edge when memWrite is high.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake and sequences the memory strobes.
- Captures read data and returns a held response to the pipeline.
- Sits between the datapath's load/store stage and the data memory instance.

Parameters:
- n, 64, data and address width in bits.
- LogSize, 10, number of implemented word-address bits; the memory holds 2^LogSize words.
- ReadLatency, 1, cycles mem_read is held before mem_data_out is sampled; legal values are 1 to 15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  n  word address.
- req_wdata  input  n  store data.
- resp_valid  output  1  response present; held until accepted.
- resp_ready  input  1  pipeline accepts the response.
- resp_rdata  output  n  load data; 0 for stores and errors.
- resp_err  output  1  address out of range.
- mem_addr  output  n  to memory Address.
- mem_wdata  output  n  to memory DataIn.
- mem_read  output  1  to memory memRead.
- mem_write  output  1  to memory memWrite.
- mem_rdata  input  n  from memory DataOut.

Behaviour:
- All outputs are registered. Clock port is clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - state = IDLE, req_ready = 1.
  - resp_valid, resp_err, mem_read and mem_write = 0.
  - resp_rdata, mem_addr, mem_wdata and the latency counter = 0.
- Reset asserted mid-operation drops the memory strobes immediately (asynchronously). The in-flight request and its response are discarded.
- States: IDLE, WRITE, READ_WAIT, RESP.
- req_ready = 1 only in IDLE. A request is accepted on a rising edge where req_valid & req_ready; the address, data and type are latched at that edge.
- Range check on accept: if req_addr[n-1:LogSize] != 0, the request is out of range.
  - Go directly to RESP with resp_err = 1 and resp_rdata = 0.
  - No memory strobe is ever asserted for it.
- Store, accepted at edge T:
  - State goes to WRITE for exactly one cycle, with mem_write = 1, mem_addr = latched address, mem_wdata = latched data.
  - The memory commits the word at the edge ending that cycle.
  - The unit then enters RESP with resp_rdata = 0 and resp_err = 0.
  - resp_valid is first high in cycle T+2.
- Load, accepted at edge T:
  - Enter READ_WAIT. mem_read = 1 and mem_addr = latched address for exactly ReadLatency cycles, tracked by a down-counter loaded with ReadLatency-1.
  - On the edge ending the last of those cycles, mem_rdata is captured into resp_rdata, mem_read drops, and the state goes to RESP.
  - resp_valid is first high in cycle T+ReadLatency+1.
- mem_write and mem_read are never high together. Both are 0 in IDLE and RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable while resp_ready = 0.
  - On an edge with resp_ready = 1, clear resp_valid and resp_err and return to IDLE. req_ready rises in the next cycle; there is no same-cycle turnaround.
- Back-to-back throughput: a store takes 3 cycles accept-to-accept; a load takes ReadLatency+2, assuming resp_ready is held at 1.
- Requests presented while req_ready = 0 are ignored and not latched. The pipeline must hold req_valid.
- mem_addr and mem_wdata retain their last values when idle (no X-driving, no Z).

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, release -> req_ready = 1, resp_valid = 0, mem_read = mem_write = 0 on every cycle.
- Store then load: store addr 0x10, data 0xDEADBEEF_01234567 -> mem_write high for exactly 1 cycle at T+1 and resp_valid at T+2 with rdata 0. Then load 0x10 (ReadLatency = 1) -> mem_read high 1 cycle, resp_rdata = 0xDEADBEEF_01234567.
- Latency sweep: ReadLatency = 3, load 0x3FF -> mem_read high exactly 3 consecutive cycles, resp_valid first at T+4, data matches the last word stored at 0x3FF.
- Out of range: load 0x400 and store 0xFFFF_0000_0000_0000 -> resp_err = 1 and rdata 0 at T+1; no mem_read or mem_write pulse; memory contents unchanged.
- Response backpressure: hold resp_ready = 0 for 5 cycles after a load -> resp_valid and resp_rdata stable and req_ready = 0 throughout; a new req_valid is not accepted until the cycle after resp_ready = 1.
- Reset mid-read: ReadLatency = 4, assert rst_n = 0 in the 2nd READ_WAIT cycle -> mem_read falls without waiting for a clock edge, no response issued, and req_ready = 1 after release.
